led_pio_blink: RTL and testbench

//  Avalon-MM slave output PIO driving WIDTH LED lines. Generalised successor of the
//  8-bit write-only LED port: parametrised width, readback, atomic bit set/clear,
//  and a per-bit blink mode driven by a shared programmable prescaler.

---
 rtl/led_pio_pkg.sv | 14 +
 rtl/led_pio_prescaler.sv | 50 +++++
 rtl/led_pio_blink.sv | 112 +++++++++++
 tb/tb_led_pio_blink.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/led_pio_pkg.sv
// Shared constants for the LED PIO: bus geometry and register word offsets.
package led_pio_pkg;

  localparam int unsigned LED_ADDR_W = 3;
  localparam int unsigned LED_BUS_W  = 32;

  localparam logic [LED_ADDR_W-1:0] LED_REG_DATA   = 3'd0;
  localparam logic [LED_ADDR_W-1:0] LED_REG_MODE   = 3'd1;
  localparam logic [LED_ADDR_W-1:0] LED_REG_OUTSET = 3'd2;
  localparam logic [LED_ADDR_W-1:0] LED_REG_OUTCLR = 3'd3;
  localparam logic [LED_ADDR_W-1:0] LED_REG_PERIOD = 3'd4;
  localparam logic [LED_ADDR_W-1:0] LED_REG_STATUS = 3'd5;

endpackage

// File: rtl/led_pio_prescaler.sv
// Shared blink prescaler: counts 0..period_i and flips phase_o on each
// terminal count. restart_i forces a clean restart (cnt=0, phase=0) and
// wins over a tick that lands on the same edge.
module led_pio_prescaler #(
  parameter int unsigned PRESC_W = 24
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [PRESC_W-1:0] period_i,
  input  logic               restart_i,
  output logic               phase_o,
  output logic [PRESC_W-1:0] cnt_o
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;
  logic               phase_q;
  logic               phase_d;
  logic               tick;

  assign tick = (cnt_q == period_i);

  // Next-state: restart has priority, then terminal-count wrap, else count up.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (restart_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Counter and phase registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/led_pio_blink.sv
// Avalon-MM output PIO for board LEDs with readback, atomic set/clear and
// per-bit blink driven by a shared programmable prescaler.
//
// Bus semantics: a write is accepted on any clk edge where chipselect=1 and
// write_n=0; a read is accepted on any edge where chipselect=1 and read_n=0.
// There are no waitstates. readdata is registered at the read edge (latency 1)
// and holds its value between reads; a read in the same cycle as a write
// returns the register contents from before that write.
module led_pio_blink
  import led_pio_pkg::*;
#(
  parameter int unsigned        WIDTH        = 8,
  parameter int unsigned        PRESC_W      = 24,
  parameter logic [WIDTH-1:0]   DATA_RESET   = '0,
  parameter logic [PRESC_W-1:0] PERIOD_RESET = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LED_ADDR_W-1:0] address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic                  read_n,
  input  logic [LED_BUS_W-1:0]  writedata,
  output logic [LED_BUS_W-1:0]  readdata,
  output logic [WIDTH-1:0]      out_port
);

  logic [WIDTH-1:0]     data_q,   data_d;
  logic [WIDTH-1:0]     mode_q,   mode_d;
  logic [PRESC_W-1:0]   period_q, period_d;
  logic [LED_BUS_W-1:0] readdata_q, readdata_d;
  logic                 restart;
  logic                 phase;
  logic [PRESC_W-1:0]   cnt;
  logic                 wr_en;
  logic                 rd_en;
  logic [WIDTH-1:0]     wd;
  logic                 unused_bits;

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & ~read_n;
  assign wd    = writedata[WIDTH-1:0];

  // Upper writedata bits and the raw counter are deliberately not consumed.
  assign unused_bits = ^{writedata, cnt};

  // Register write decode; OUTSET/OUTCLR are read-modify-write on DATA.
  always_comb begin
    data_d   = data_q;
    mode_d   = mode_q;
    period_d = period_q;
    restart  = 1'b0;
    if (wr_en) begin
      case (address)
        LED_REG_DATA:   data_d = wd;
        LED_REG_MODE:   mode_d = wd;
        LED_REG_OUTSET: data_d = data_q | wd;
        LED_REG_OUTCLR: data_d = data_q & ~wd;
        LED_REG_PERIOD: begin
          period_d = writedata[PRESC_W-1:0];
          restart  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Readback mux from current (pre-write) register values.
  always_comb begin
    readdata_d = '0;
    case (address)
      LED_REG_DATA:   readdata_d[WIDTH-1:0]   = data_q;
      LED_REG_MODE:   readdata_d[WIDTH-1:0]   = mode_q;
      LED_REG_PERIOD: readdata_d[PRESC_W-1:0] = period_q;
      LED_REG_STATUS: readdata_d[0]           = phase;
      default: ;
    endcase
  end

  // Control registers and registered read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= DATA_RESET;
      mode_q     <= '0;
      period_q   <= PERIOD_RESET;
      readdata_q <= '0;
    end else begin
      data_q   <= data_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      if (rd_en) begin
        readdata_q <= readdata_d;
      end
    end
  end

  led_pio_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk_i     (clk),
    .rst_i     (reset),
    .period_i  (period_q),
    .restart_i (restart),
    .phase_o   (phase),
    .cnt_o     (cnt)
  );

  assign readdata = readdata_q;
  // Blinking bits are gated by phase; static bits pass DATA straight through.
  assign out_port = data_q & (~mode_q | {WIDTH{phase}});

endmodule

// File: tb/tb_led_pio_blink.sv
// Directed bench for led_pio_blink: register access, set/clear, blink
// timing, period restart, ignored accesses and asynchronous reset.
module tb_led_pio_blink;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned PRESC_W = 24;
  localparam logic [WIDTH-1:0] DATA_RST = 8'h3C;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [WIDTH-1:0] out_port;

  int tests_run;
  int tests_failed;
  logic [31:0] exp_q[$];

  led_pio_blink #(
    .WIDTH        (WIDTH),
    .PRESC_W      (PRESC_W),
    .DATA_RESET   (DATA_RST),
    .PERIOD_RESET (24'd0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus cycle, starting and ending on a negedge (exactly one posedge).
  task automatic bus_cycle(input logic cs, input logic wn, input logic rn,
                           input logic [2:0] addr, input logic [31:0] wdat);
    chipselect = cs;
    write_n    = wn;
    read_n     = rn;
    address    = addr;
    writedata  = wdat;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    address    = 3'd0;
    writedata  = 32'h0;
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] wdat);
    bus_cycle(1'b1, 1'b0, 1'b1, addr, wdat);
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  // Read with the expected value queued on the scoreboard.
  task automatic read_check(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    bus_cycle(1'b1, 1'b1, 1'b0, addr, 32'h0);
    e = exp_q.pop_front();
    check(tag, readdata, e);
  endtask

  initial begin
    int k;
    logic [31:0] e;
    tests_run    = 0;
    tests_failed = 0;
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    address    = 3'd0;
    writedata  = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_out_port", {24'h0, out_port}, {24'h0, DATA_RST});
    check("rst_readdata", readdata, 32'h0);
    reset = 1'b0;

    // DATA write and readback
    bus_write(3'd0, 32'hFFFF_FFA5);
    check("data_out_port", {24'h0, out_port}, 32'hA5);
    read_check("data_read", 3'd0, 32'hA5);
    idle();
    check("readdata_hold", readdata, 32'hA5);

    // Atomic set / clear
    bus_write(3'd2, 32'h0F);
    check("outset_port", {24'h0, out_port}, 32'hAF);
    read_check("outset_read", 3'd0, 32'hAF);
    bus_write(3'd3, 32'h81);
    check("outclr_port", {24'h0, out_port}, 32'h2E);
    read_check("read_outset_reg", 3'd2, 32'h0);
    read_check("read_outclr_reg", 3'd3, 32'h0);

    // Blink, P=3: phase after k-th edge since the PERIOD write is (k/4)%2
    bus_write(3'd4, 32'd3);   // k=0
    bus_write(3'd1, 32'h01);  // k=1
    bus_write(3'd0, 32'h03);  // k=2
    k = 2;
    check($sformatf("blink_k%0d", k), {24'h0, out_port}, 32'h2 | ((k / 4) % 2));
    while (k < 14) begin
      idle();
      k++;
      check($sformatf("blink_k%0d", k), {24'h0, out_port}, 32'h2 | ((k / 4) % 2));
    end
    read_check("status_phase", 3'd5, 32'h1);   // samples phase after k=14
    read_check("period_read", 3'd4, 32'd3);    // k=16, tick edge
    idle(); idle(); idle();                    // k=19

    // PERIOD write on the tick edge (k=20): restart wins, phase stays 0
    bus_write(3'd4, 32'd2);
    check("restart_j0", {24'h0, out_port}, 32'h2);
    for (int j = 1; j <= 7; j++) begin
      idle();
      e = 32'h2 | ((j / 3) % 2);
      check($sformatf("restart_j%0d", j), {24'h0, out_port}, e);
    end

    // Ignored writes
    bus_cycle(1'b0, 1'b0, 1'b1, 3'd0, 32'hFF);
    bus_cycle(1'b1, 1'b1, 1'b1, 3'd0, 32'hFF);
    bus_write(3'd5, 32'hFF);
    bus_write(3'd6, 32'hFF);
    bus_write(3'd7, 32'hFF);
    read_check("ign_data", 3'd0, 32'h03);
    read_check("ign_mode", 3'd1, 32'h01);
    read_check("ign_period", 3'd4, 32'd2);
    read_check("read_off6", 3'd6, 32'h0);
    read_check("read_off7", 3'd7, 32'h0);

    // Simultaneous read and write of DATA returns the old value
    bus_cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'h81);
    check("rdwr_old", readdata, 32'h03);
    read_check("rdwr_new", 3'd0, 32'h81);

    // Asynchronous reset in the middle of blinking
    #2 reset = 1'b1;
    #1;
    check("async_rst_port", {24'h0, out_port}, {24'h0, DATA_RST});
    check("async_rst_rdata", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    read_check("post_rst_status", 3'd5, 32'h0);
    read_check("post_rst_mode", 3'd1, 32'h0);
    read_check("post_rst_period", 3'd4, 32'h0);
    read_check("post_rst_data", 3'd0, {24'h0, DATA_RST});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
